// File: rtl/sprite_compositor_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : sprite_compositor_pkg                                        |
// | Description : Shared constants, types and helpers for the sprite           |
// |               compositor: screen geometry, colour width, game object       |
// |               enumeration (which sizes the default sprite channel count),  |
// |               the sprite-position record and RGB565->RGB888 expansion.     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package sprite_compositor_pkg;

   // Screen / SRAM frame-buffer geometry
   localparam int SCREEN_W_DEF = 640;
   localparam int SCREEN_H_DEF = 480;
   localparam int COLOR_WIDTH  = 24;

   // Game objects that own a sprite channel; the channel count follows this list.
   typedef enum logic [1:0] {
      OBJ_PLAYER  = 2'd0,
      OBJ_ENEMY   = 2'd1,
      OBJ_BULLET0 = 2'd2,
      OBJ_BULLET1 = 2'd3
   } object_id_e;

   localparam int OBJ_COUNT = 4;

   // Position record as produced by the game logic at the default coordinate widths.
   typedef struct packed {
      logic signed [9:0] x;
      logic signed [8:0] y;
      logic              en;
   } sprite_pos_t;

   // Replicate the top bits into the low bits so full-scale 565 maps to full-scale 888.
   function automatic logic [COLOR_WIDTH-1:0] rgb565_to_888(input logic [15:0] d);
      return {d[15:11], d[15:13], d[10:5], d[10:9], d[4:0], d[4:2]};
   endfunction

endpackage
`default_nettype wire

// File: rtl/sprite_compositor_hit_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : sprite_hit_unit                                              |
// | Description : One sprite channel hit test. Computes the pixel position     |
// |               relative to the sprite origin, decides whether it lies       |
// |               inside the SPRITE_SIZE square and registers the local u/v    |
// |               LUT address together with the in-box flag.                   |
// | Ports       : i_clk, i_rst_n    clock / async active-low reset             |
// |               i_active          pixel is on-screen (else forced out)       |
// |               i_h, i_v          requested column / row (unsigned)          |
// |               i_x, i_y          sprite origin (two's complement)           |
// |               i_en              channel enable (latched copy)              |
// |               o_u, o_v          local LUT coordinates (0 when outside)     |
// |               o_inbox           pixel lies inside the sprite               |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module sprite_hit_unit #(
   parameter int H_WIDTH     = 10,
   parameter int V_WIDTH     = 9,
   parameter int SPRITE_SIZE = 32
) (
   input  logic                           i_clk,
   input  logic                           i_rst_n,
   input  logic                           i_active,
   input  logic [H_WIDTH-1:0]             i_h,
   input  logic [V_WIDTH-1:0]             i_v,
   input  logic [H_WIDTH-1:0]             i_x,
   input  logic [V_WIDTH-1:0]             i_y,
   input  logic                           i_en,
   output logic [$clog2(SPRITE_SIZE)-1:0] o_u,
   output logic [$clog2(SPRITE_SIZE)-1:0] o_v,
   output logic                           o_inbox
);

   localparam int UW = $clog2(SPRITE_SIZE);

   logic [H_WIDTH:0] w_du;
   logic [V_WIDTH:0] w_dv;
   logic             w_inbox;

   // One extra bit so a negative origin cannot alias a far-right pixel into the box.
   assign w_du = {1'b0, i_h} - {i_x[H_WIDTH-1], i_x};
   assign w_dv = {1'b0, i_v} - {i_y[V_WIDTH-1], i_y};

   // SPRITE_SIZE is a power of two: 0 <= d < SPRITE_SIZE <=> all bits from UW up are zero.
   assign w_inbox = i_en && i_active &&
                    (w_du[H_WIDTH:UW] == '0) && (w_dv[V_WIDTH:UW] == '0);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_u     <= '0;
         o_v     <= '0;
         o_inbox <= 1'b0;
      end else begin
         o_u     <= w_inbox ? w_du[UW-1:0] : '0;
         o_v     <= w_inbox ? w_dv[UW-1:0] : '0;
         o_inbox <= w_inbox;
      end
   end

endmodule
`default_nettype wire

// File: rtl/sprite_compositor.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : sprite_compositor                                            |
// | Description : Per-pixel layer mixer. Composites NUM_SPRITES sprite         |
// |               channels (channel 0 on top) over an RGB565 SRAM background   |
// |               and returns one RGB888 colour per pixel request with a       |
// |               fixed latency. Sprite positions are latched per frame and    |
// |               opaque overlaps are reported per channel once per frame.     |
// | Ports       : i_clk, i_rst_n           pixel clock / async active-low rst  |
// |               i_frame_start            latch positions, publish collisions |
// |               i_spr_x/y/en             per-channel position and enable     |
// |               i_pix_valid/h/v          pixel request                       |
// |               o_sram_addr/i_sram_data  background fetch                    |
// |               o_spr_u/v, i_spr_color   sprite LUT lookup                   |
// |               o_color/o_color_valid    composited pixel                    |
// |               o_layer                  one-hot winning sprite (0 = bg)     |
// |               o_collide                previous-frame overlap flags        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module sprite_compositor
   import sprite_compositor_pkg::*;
#(
   parameter int NUM_SPRITES  = OBJ_COUNT,
   parameter int SPRITE_SIZE  = 32,
   parameter int H_WIDTH      = 10,
   parameter int V_WIDTH      = 9,
   parameter int SCREEN_W     = SCREEN_W_DEF,
   parameter int SCREEN_H     = SCREEN_H_DEF,
   parameter int SRAM_LATENCY = 2,
   parameter int SRAM_ADDR_W  = 20
) (
   input  logic                                       i_clk,
   input  logic                                       i_rst_n,
   input  logic                                       i_frame_start,
   input  logic [NUM_SPRITES*H_WIDTH-1:0]             i_spr_x,
   input  logic [NUM_SPRITES*V_WIDTH-1:0]             i_spr_y,
   input  logic [NUM_SPRITES-1:0]                     i_spr_en,
   input  logic                                       i_pix_valid,
   input  logic [H_WIDTH-1:0]                         i_pix_h,
   input  logic [V_WIDTH-1:0]                         i_pix_v,
   output logic [SRAM_ADDR_W-1:0]                     o_sram_addr,
   input  logic [15:0]                                i_sram_data,
   output logic [NUM_SPRITES*$clog2(SPRITE_SIZE)-1:0] o_spr_u,
   output logic [NUM_SPRITES*$clog2(SPRITE_SIZE)-1:0] o_spr_v,
   input  logic [NUM_SPRITES*COLOR_WIDTH-1:0]         i_spr_color,
   output logic [COLOR_WIDTH-1:0]                     o_color,
   output logic                                       o_color_valid,
   output logic [NUM_SPRITES-1:0]                     o_layer,
   output logic [NUM_SPRITES-1:0]                     o_collide
);

   localparam int UW    = $clog2(SPRITE_SIZE);
   localparam int MW    = H_WIDTH + V_WIDTH + 1;
   // Mix point is the later of LUT colour arrival (request+2) and SRAM data (request+L).
   localparam int C_DLY = (SRAM_LATENCY > 2) ? SRAM_LATENCY - 2 : 0;
   localparam int S_DLY = (SRAM_LATENCY < 2) ? 2 - SRAM_LATENCY : 0;
   localparam int PW    = 2 + NUM_SPRITES + NUM_SPRITES*COLOR_WIDTH;

   localparam logic [H_WIDTH:0] c_screen_w = (H_WIDTH+1)'(SCREEN_W);
   localparam logic [V_WIDTH:0] c_screen_h = (V_WIDTH+1)'(SCREEN_H);

   // ---------------- frame latch ----------------
   logic [NUM_SPRITES*H_WIDTH-1:0] r_shadow_x;
   logic [NUM_SPRITES*V_WIDTH-1:0] r_shadow_y;
   logic [NUM_SPRITES-1:0]         r_shadow_en;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_shadow_x  <= '0;
         r_shadow_y  <= '0;
         r_shadow_en <= '0;
      end else if (i_frame_start) begin
         r_shadow_x  <= i_spr_x;
         r_shadow_y  <= i_spr_y;
         r_shadow_en <= i_spr_en;
      end
   end

   // ---------------- stage 0: address and hit test ----------------
   logic          w_onscreen;
   logic [MW-1:0] w_addr_full;
   logic          r0_valid, r0_off;
   logic [NUM_SPRITES-1:0] r0_inbox;

   assign w_onscreen  = ({1'b0, i_pix_h} < c_screen_w) && ({1'b0, i_pix_v} < c_screen_h);
   assign w_addr_full = MW'(i_pix_v) * MW'(SCREEN_W) + MW'(i_pix_h);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_sram_addr <= '0;
         r0_valid    <= 1'b0;
         r0_off      <= 1'b0;
      end else begin
         o_sram_addr <= w_onscreen ? SRAM_ADDR_W'(w_addr_full) : '0;
         r0_valid    <= i_pix_valid;
         r0_off      <= !w_onscreen;
      end
   end

   generate
      for (genvar k = 0; k < NUM_SPRITES; k++) begin : g_chan
         sprite_hit_unit #(
            .H_WIDTH     (H_WIDTH),
            .V_WIDTH     (V_WIDTH),
            .SPRITE_SIZE (SPRITE_SIZE)
         ) u_hit (
            .i_clk    (i_clk),
            .i_rst_n  (i_rst_n),
            .i_active (w_onscreen),
            .i_h      (i_pix_h),
            .i_v      (i_pix_v),
            .i_x      (r_shadow_x[k*H_WIDTH +: H_WIDTH]),
            .i_y      (r_shadow_y[k*V_WIDTH +: V_WIDTH]),
            .i_en     (r_shadow_en[k]),
            .o_u      (o_spr_u[k*UW +: UW]),
            .o_v      (o_spr_v[k*UW +: UW]),
            .o_inbox  (r0_inbox[k])
         );
      end
   endgenerate

   // ---------------- stage 1: LUT colour arrives ----------------
   logic                   r1_valid, r1_off;
   logic [NUM_SPRITES-1:0] r1_inbox;
   logic [NUM_SPRITES-1:0] w_opaque;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r1_valid <= 1'b0;
         r1_off   <= 1'b0;
         r1_inbox <= '0;
      end else begin
         r1_valid <= r0_valid;
         r1_off   <= r0_off;
         r1_inbox <= r0_inbox;
      end
   end

   always_comb begin
      w_opaque = '0;
      for (int k = 0; k < NUM_SPRITES; k++)
         w_opaque[k] = r1_inbox[k] && (i_spr_color[k*COLOR_WIDTH +: COLOR_WIDTH] != '0);
   end

   // ---------------- alignment pipes ----------------
   logic [PW-1:0] w_s1, w_mix;
   logic [15:0]   w_sram;

   assign w_s1 = {r1_valid, r1_off, w_opaque, i_spr_color};

   generate
      if (C_DLY > 0) begin : g_cpipe
         logic [PW-1:0] r_pipe [C_DLY];
         always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
               for (int i = 0; i < C_DLY; i++) r_pipe[i] <= '0;
            end else begin
               r_pipe[0] <= w_s1;
               for (int i = 1; i < C_DLY; i++) r_pipe[i] <= r_pipe[i-1];
            end
         end
         assign w_mix = r_pipe[C_DLY-1];
      end else begin : g_cdirect
         assign w_mix = w_s1;
      end

      if (S_DLY > 0) begin : g_spipe
         logic [15:0] r_pipe [S_DLY];
         always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
               for (int i = 0; i < S_DLY; i++) r_pipe[i] <= '0;
            end else begin
               r_pipe[0] <= i_sram_data;
               for (int i = 1; i < S_DLY; i++) r_pipe[i] <= r_pipe[i-1];
            end
         end
         assign w_sram = r_pipe[S_DLY-1];
      end else begin : g_sdirect
         assign w_sram = i_sram_data;
      end
   endgenerate

   // ---------------- mix stage ----------------
   logic                          m_valid, m_off;
   logic [NUM_SPRITES-1:0]        m_opaque;
   logic [NUM_SPRITES*COLOR_WIDTH-1:0] m_col;
   logic [NUM_SPRITES-1:0]        w_win;
   logic [COLOR_WIDTH-1:0]        w_win_col;
   logic                          w_found;
   logic                          w_multi;
   logic [NUM_SPRITES-1:0]        r_acc;

   assign m_valid  = w_mix[PW-1];
   assign m_off    = w_mix[PW-2];
   assign m_opaque = w_mix[PW-3 -: NUM_SPRITES];
   assign m_col    = w_mix[NUM_SPRITES*COLOR_WIDTH-1:0];

   // x & (x-1) is non-zero exactly when two or more bits are set.
   assign w_multi = |(m_opaque & (m_opaque - NUM_SPRITES'(1)));

   always_comb begin
      w_win     = '0;
      w_win_col = '0;
      w_found   = 1'b0;
      for (int k = 0; k < NUM_SPRITES; k++) begin
         if (!w_found && m_opaque[k]) begin
            w_win[k]  = 1'b1;
            w_win_col = m_col[k*COLOR_WIDTH +: COLOR_WIDTH];
            w_found   = 1'b1;
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_color       <= '0;
         o_color_valid <= 1'b0;
         o_layer       <= '0;
         o_collide     <= '0;
         r_acc         <= '0;
      end else begin
         o_color_valid <= m_valid;
         if (m_valid) begin
            o_layer <= w_win;
            if (m_off)        o_color <= '0;
            else if (w_found) o_color <= w_win_col;
            else              o_color <= rgb565_to_888(w_sram);
         end
         // A collision seen on the pulse edge belongs to the frame that starts there.
         if (i_frame_start) begin
            o_collide <= r_acc;
            r_acc     <= (m_valid && w_multi) ? m_opaque : '0;
         end else if (m_valid && w_multi) begin
            r_acc <= r_acc | m_opaque;
         end
      end
   end

endmodule
`default_nettype wire
